iir_mult_scheduler: RTL and testbench

Sequencer for one second-order IIR section, y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]. The section shares a single external 4x4 signed Baugh-Wooley multiplier, and this block time-multiplexes the five taps onto it, one product per cycle. The block holds the delay line and the accumulator, and quantises and saturates the result back to 4 bits. Samples enter and leave through valid/ready handshakes.

---
 rtl/iir_mult_scheduler_if.sv | 33 +++
 rtl/iir_mult_scheduler.sv | 166 ++++++++++++++++
 tb/tb_iir_mult_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/iir_mult_scheduler_if.sv
// Handshake and shared-multiplier bus of the IIR section sequencer.
// The slave side is the sequencer; the master side is its environment.
interface iir_mult_scheduler_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] in_data;
  logic signed [3:0] coef_b0;
  logic signed [3:0] coef_b1;
  logic signed [3:0] coef_b2;
  logic signed [3:0] coef_a1;
  logic signed [3:0] coef_a2;
  logic              flush;
  logic              mul_en;
  logic signed [3:0] mul_a;
  logic signed [3:0] mul_b;
  logic signed [7:0] mul_p;
  logic              out_valid;
  logic              out_ready;
  logic signed [3:0] out_data;
  logic              busy;

  modport slave (
    input  in_valid, in_data, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
    input  flush, mul_p, out_ready,
    output in_ready, mul_en, mul_a, mul_b, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
    output flush, mul_p, out_ready,
    input  in_ready, mul_en, mul_a, mul_b, out_valid, out_data, busy
  );
endinterface

// File: rtl/iir_mult_scheduler.sv
// Second-order IIR section that time-multiplexes its five taps onto one
// external 4x4 signed multiplier, then shifts and saturates y[n] to 4 bits.
module iir_mult_scheduler #(
  parameter int unsigned SHIFT = 3
) (
  input logic                 clk,
  input logic                 rst,
  iir_mult_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, OUT = 2'd2} state_t;

  state_t            state_r, state_s;
  logic        [2:0] tap_r, tap_s;
  logic signed [10:0] acc_r, acc_s, acc_f_s, prod_s;
  logic signed [3:0] xs_r, xs_s, x1_r, x1_s, x2_r, x2_s, y1_r, y1_s, y2_r, y2_s;
  logic signed [3:0] b0_r, b0_s, b1_r, b1_s, b2_r, b2_s, a1_r, a1_s, a2_r, a2_s;
  logic signed [3:0] out_data_r, out_data_s, res_s, mul_a_s, mul_b_s;
  logic              out_valid_r, out_valid_s, mul_en_s, sub_s, in_ready_s;

  function automatic logic signed [3:0] sat4(input logic signed [10:0] v);
    if (v > 11'sd7) begin
      sat4 = 4'sb0111;
    end else if (v < -11'sd8) begin
      sat4 = 4'sb1000;
    end else begin
      sat4 = v[3:0];
    end
  endfunction

  assign prod_s        = {{3{bus.mul_p[7]}}, bus.mul_p};
  assign in_ready_s    = (state_r == IDLE) && !rst;
  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = (state_r != IDLE);
  assign bus.mul_en    = mul_en_s;
  assign bus.mul_a     = mul_a_s;
  assign bus.mul_b     = mul_b_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  // Next-state, operand selection and datapath updates for the whole sequencer.
  always_comb begin
    state_s     = state_r;
    tap_s       = tap_r;
    acc_s       = acc_r;
    acc_f_s     = acc_r;
    xs_s        = xs_r;
    x1_s        = x1_r;
    x2_s        = x2_r;
    y1_s        = y1_r;
    y2_s        = y2_r;
    b0_s        = b0_r;
    b1_s        = b1_r;
    b2_s        = b2_r;
    a1_s        = a1_r;
    a2_s        = a2_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    res_s       = 4'sd0;
    mul_en_s    = 1'b0;
    mul_a_s     = 4'sd0;
    mul_b_s     = 4'sd0;
    sub_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // Flush and accept may coincide; the new sample then sees zero history.
        if (bus.flush) begin
          x1_s = 4'sd0;
          x2_s = 4'sd0;
          y1_s = 4'sd0;
          y2_s = 4'sd0;
        end else begin
          x1_s = x1_r;
        end
        if (bus.in_valid && in_ready_s) begin
          xs_s    = bus.in_data;
          b0_s    = bus.coef_b0;
          b1_s    = bus.coef_b1;
          b2_s    = bus.coef_b2;
          a1_s    = bus.coef_a1;
          a2_s    = bus.coef_a2;
          acc_s   = 11'sd0;
          tap_s   = 3'd0;
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        mul_en_s = 1'b1;
        case (tap_r)
          3'd0:    begin mul_a_s = xs_r; mul_b_s = b0_r; sub_s = 1'b0; end
          3'd1:    begin mul_a_s = x1_r; mul_b_s = b1_r; sub_s = 1'b0; end
          3'd2:    begin mul_a_s = x2_r; mul_b_s = b2_r; sub_s = 1'b0; end
          3'd3:    begin mul_a_s = y1_r; mul_b_s = a1_r; sub_s = 1'b1; end
          3'd4:    begin mul_a_s = y2_r; mul_b_s = a2_r; sub_s = 1'b1; end
          default: begin mul_a_s = 4'sd0; mul_b_s = 4'sd0; sub_s = 1'b0; end
        endcase
        acc_f_s = sub_s ? (acc_r - prod_s) : (acc_r + prod_s);
        acc_s   = acc_f_s;
        if (tap_r == 3'd4) begin
          res_s       = sat4(acc_f_s >>> SHIFT);
          out_data_s  = res_s;
          out_valid_s = 1'b1;
          x2_s        = x1_r;
          x1_s        = xs_r;
          y2_s        = y1_r;
          y1_s        = res_s;
          tap_s       = 3'd0;
          state_s     = OUT;
        end else begin
          tap_s = tap_r + 3'd1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      tap_r       <= 3'd0;
      acc_r       <= 11'sd0;
      xs_r        <= 4'sd0;
      x1_r        <= 4'sd0;
      x2_r        <= 4'sd0;
      y1_r        <= 4'sd0;
      y2_r        <= 4'sd0;
      b0_r        <= 4'sd0;
      b1_r        <= 4'sd0;
      b2_r        <= 4'sd0;
      a1_r        <= 4'sd0;
      a2_r        <= 4'sd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 4'sd0;
    end else begin
      state_r     <= state_s;
      tap_r       <= tap_s;
      acc_r       <= acc_s;
      xs_r        <= xs_s;
      x1_r        <= x1_s;
      x2_r        <= x2_s;
      y1_r        <= y1_s;
      y2_r        <= y2_s;
      b0_r        <= b0_s;
      b1_r        <= b1_s;
      b2_r        <= b2_s;
      a1_r        <= a1_s;
      a2_r        <= a2_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
    end
  end

endmodule

// File: tb/tb_iir_mult_scheduler.sv
// Directed and randomized bench for iir_mult_scheduler against an
// arithmetic reference of the biquad recursion.
module tb_iir_mult_scheduler;
  localparam int SHIFT = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   hx1, hx2, hy1, hy2;

  iir_mult_scheduler_if bus ();

  iir_mult_scheduler #(.SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The external multiplier the sequencer drives.
  assign bus.mul_p = bus.mul_a * bus.mul_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_y(input int x, input int b0, input int b1,
                               input int b2, input int a1, input int a2);
    int acc;
    int r;
    acc = b0 * x + b1 * hx1 + b2 * hx2 - a1 * hy1 - a2 * hy2;
    r = acc >>> SHIFT;
    if (r > 7) r = 7;
    if (r < -8) r = -8;
    return r;
  endfunction

  task automatic scramble_inputs();
    bus.in_data = 4'($urandom_range(15));
    bus.coef_b0 = 4'($urandom_range(15));
    bus.coef_b1 = 4'($urandom_range(15));
    bus.coef_b2 = 4'($urandom_range(15));
    bus.coef_a1 = 4'($urandom_range(15));
    bus.coef_a2 = 4'($urandom_range(15));
  endtask

  // One full sample: accept, five taps, output held for 'hold' cycles, handshake.
  task automatic send(input int x, input int b0, input int b1, input int b2,
                      input int a1, input int a2, input int hold,
                      input bit fl_acc, input bit fl_mid);
    int exp_y;
    int ops[5];
    int cfs[5];
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'(x);
    bus.coef_b0   = 4'(b0);
    bus.coef_b1   = 4'(b1);
    bus.coef_b2   = 4'(b2);
    bus.coef_a1   = 4'(a1);
    bus.coef_a2   = 4'(a2);
    bus.flush     = fl_acc;
    bus.out_ready = 1'b0;
    #1;
    check("in_ready_idle", bus.in_ready, 1);
    check("mul_en_idle", bus.mul_en, 0);
    if (fl_acc) begin
      hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
    end
    ops = '{x, hx1, hx2, hy1, hy2};
    cfs = '{b0, b1, b2, a1, a2};
    exp_y = ref_y(x, b0, b1, b2, a1, a2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = fl_mid;
    scramble_inputs();
    for (int t = 0; t < 5; t++) begin
      check("mul_en_tap", bus.mul_en, 1);
      check("mul_a_tap", bus.mul_a, ops[t]);
      check("mul_b_tap", bus.mul_b, cfs[t]);
      check("in_ready_mul", bus.in_ready, 0);
      if (t == 2) scramble_inputs();
      @(negedge clk);
    end
    bus.flush = 1'b0;
    check("out_valid_rise", bus.out_valid, 1);
    check("out_data", bus.out_data, exp_y);
    check("mul_en_out", bus.mul_en, 0);
    check("mul_a_gated", bus.mul_a, 0);
    hx2 = hx1; hx1 = x; hy2 = hy1; hy1 = exp_y;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("out_valid_hold", bus.out_valid, 1);
      check("out_data_hold", bus.out_data, exp_y);
      check("in_ready_hold", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_fall", bus.out_valid, 0);
    check("out_data_kept", bus.out_data, exp_y);
    check("in_ready_back", bus.in_ready, 1);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int rx, rb0, rb1, rb2, ra1, ra2;
    n_vec = 0; n_err = 0;
    hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 4'sd0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.coef_b0 = 4'sd0; bus.coef_b1 = 4'sd0; bus.coef_b2 = 4'sd0;
    bus.coef_a1 = 4'sd0; bus.coef_a2 = 4'sd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_mul_en", bus.mul_en, 0);
    check("rst_mul_b", bus.mul_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic gain, recursion, saturation and floor cases.
    send(6, 4, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(6, 4, 0, 0, -4, 0, 0, 1'b1, 1'b0);
    send(6, 4, 0, 0, -4, 0, 0, 1'b0, 1'b0);
    send(-8, -8, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(-8, 7, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(4, 2, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(0, 1, 0, 0, 1, 0, 0, 1'b0, 1'b0);

    // Backpressure, flush alone in IDLE, then flush pulsed mid-sample.
    send(5, 3, 2, 1, -2, 1, 10, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
    send(6, 4, 0, 0, -4, 0, 0, 1'b0, 1'b0);
    send(3, 2, 3, -1, 2, -3, 0, 1'b0, 1'b1);

    // Reset asserted at tap 2 discards the sample and clears history.
    bus.in_valid = 1'b1; bus.in_data = 4'sd5; bus.coef_b0 = 4'sd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("tap2_mul_en", bus.mul_en, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_mul_en", bus.mul_en, 0);
    check("arst_mul_a", bus.mul_a, 0);
    check("arst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
    @(negedge clk);
    send(6, 4, 0, 0, -4, 0, 0, 1'b0, 1'b0);

    // Randomized samples against the reference.
    for (int i = 0; i < 40; i++) begin
      rx  = int'($urandom_range(15)) - 8;
      rb0 = int'($urandom_range(15)) - 8;
      rb1 = int'($urandom_range(15)) - 8;
      rb2 = int'($urandom_range(15)) - 8;
      ra1 = int'($urandom_range(15)) - 8;
      ra2 = int'($urandom_range(15)) - 8;
      send(rx, rb0, rb1, rb2, ra1, ra2, int'($urandom_range(3)),
           ($urandom_range(4) == 0), ($urandom_range(3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
